// File: rtl/div_pkg.sv
// Shared types and helpers for the divider issue/writeback controller.
// Holds the micro-op encoding, the controller state enum, the zero-divisor
// quotient constant and the small op-decoding helpers used by the top.
package div_pkg;

  // Divide micro-op encoding as delivered by the execute stage
  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_MOD  = 2'd1,
    OP_DIVU = 2'd2,
    OP_MODU = 2'd3
  } div_op_e;

  // Controller sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } div_ctrl_state_e;

  // Quotient reported for any division by zero (all ones)
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  // DIV and MOD are signed; DIVU and MODU are unsigned
  function automatic logic op_is_signed(input div_op_e op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Remainder-returning ops are the modulo forms; the divide forms give the quotient
  function automatic logic op_is_mod(input div_op_e op);
    return (op == OP_MOD) || (op == OP_MODU);
  endfunction

  // Pick the architectural result out of a {remainder, quotient} pair
  function automatic logic [31:0] select_result(input div_op_e op,
                                                input logic [63:0] rem_quot);
    return op_is_mod(op) ? rem_quot[63:32] : rem_quot[31:0];
  endfunction

endpackage

// File: rtl/div_result_cache.sv
// One-entry last-result cache for div_issue_ctrl.
// Remembers the operands, signedness and full {remainder, quotient} of the
// most recent completed divider run so that a DIV followed by a MOD (or a
// repeat) of the same operands can skip the iterative divider entirely.
// Only instantiated when DIV_RESULT_CACHE_EN is defined.
module div_result_cache
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lookup_a,
  input  logic [31:0] lookup_b,
  input  logic        lookup_sign,
  output logic        hit,
  output logic [63:0] hit_result,
  input  logic        wr_en,
  input  logic [31:0] wr_a,
  input  logic [31:0] wr_b,
  input  logic        wr_sign,
  input  logic [63:0] wr_result
);

  logic        entry_valid;
  logic [31:0] entry_a;
  logic [31:0] entry_b;
  logic        entry_sign;
  logic [63:0] entry_result;

  // Overwrite the single entry with each completed divider run; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_valid  <= 1'b0;
      entry_a      <= '0;
      entry_b      <= '0;
      entry_sign   <= 1'b0;
      entry_result <= '0;
    end else if (wr_en) begin
      entry_valid  <= 1'b1;
      entry_a      <= wr_a;
      entry_b      <= wr_b;
      entry_sign   <= wr_sign;
      entry_result <= wr_result;
    end
  end

  // A hit needs a live entry whose dividend, divisor and signedness all match
  always_comb begin
    hit        = entry_valid && (entry_a == lookup_a) && (entry_b == lookup_b) &&
                 (entry_sign == lookup_sign);
    hit_result = entry_result;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/writeback controller between the integer execute pipe and the
// iterative radix-4 divider. Accepts one DIV/MOD/DIVU/MODU op at a time,
// pulses the divider start, waits for the divider to drop busy, selects
// quotient or remainder and holds the result until writeback takes it.
// Zero divisors are answered directly without touching the divider.
// Optional feature macro: DIV_RESULT_CACHE_EN adds a one-entry last-result
// cache (div_result_cache) that short-circuits repeated operand pairs.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_src_a,
  input  logic [31:0]      in_src_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_start,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  output logic             div_sign,
  input  logic [63:0]      div_result,
  input  logic             div_busy
);

  div_ctrl_state_e  state;
  div_op_e          op_q;
  logic [TAG_W-1:0] tag_q;
  logic             wait_armed;
  div_op_e          accept_op;
  logic             capture;
  logic             cache_hit;
  logic [63:0]      cache_result;

  // New requests are only taken when idle and not being flushed
  assign in_ready  = (state == IDLE) && !flush;
  assign accept_op = div_op_e'(in_op);

  // The divider result is taken in a WAIT cycle after the first, once busy drops
  assign capture = (state == WAIT) && wait_armed && !div_busy && !flush;

`ifdef DIV_RESULT_CACHE_EN
  logic cache_lookup_hit;

  div_result_cache u_cache (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_a    (in_src_a),
    .lookup_b    (in_src_b),
    .lookup_sign (op_is_signed(accept_op)),
    .hit         (cache_lookup_hit),
    .hit_result  (cache_result),
    .wr_en       (capture),
    .wr_a        (div_a),
    .wr_b        (div_b),
    .wr_sign     (div_sign),
    .wr_result   (div_result)
  );

  assign cache_hit = cache_lookup_hit;
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  // Sequencing FSM with all outputs registered; flush overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_DIV;
      tag_q      <= '0;
      wait_armed <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
      div_start  <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      div_sign   <= 1'b0;
    end else begin
      div_start <= 1'b0;
      if (flush) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              op_q       <= accept_op;
              tag_q      <= in_tag;
              div_a      <= in_src_a;
              div_b      <= in_src_b;
              div_sign   <= op_is_signed(accept_op);
              wait_armed <= 1'b0;
              if (in_src_b == 32'd0) begin
                state     <= DONE;
                out_valid <= 1'b1;
                out_data  <= op_is_mod(accept_op) ? in_src_a : DIV_ZERO_QUOT;
                out_tag   <= in_tag;
              end else if (cache_hit) begin
                state     <= DONE;
                out_valid <= 1'b1;
                out_data  <= select_result(accept_op, cache_result);
                out_tag   <= in_tag;
              end else begin
                state     <= LAUNCH;
                div_start <= 1'b1;
              end
            end
          end
          LAUNCH: begin
            state <= WAIT;
          end
          WAIT: begin
            if (!wait_armed) begin
              wait_armed <= 1'b1;
            end else if (!div_busy) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= select_result(op_q, div_result);
              out_tag   <= tag_q;
            end
          end
          DONE: begin
            if (out_ready) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // capture is consumed inside the cache only when that feature is built in
  logic unused_capture;
  assign unused_capture = capture;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural divider model
// and an arithmetic reference for expected results, latency and start pulses.
`timescale 1ns/1ps
module tb_div_issue_ctrl;

  localparam int TAG_W = 5;
  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_MOD  = 2'd1;
  localparam logic [1:0] OP_DIVU = 2'd2;
  localparam logic [1:0] OP_MODU = 2'd3;

`ifdef DIV_RESULT_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'd0;
  logic [31:0]      in_src_a = '0;
  logic [31:0]      in_src_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             div_start;
  logic [31:0]      div_a;
  logic [31:0]      div_b;
  logic             div_sign;
  logic [63:0]      div_result = 'x;
  logic             div_busy = 1'bx;

  int vectors = 0;
  int miscompares = 0;

  // divider model state
  int          busy_left = 0;
  int          start_count = 0;
  int          last_n = 0;
  logic [63:0] pending_result;

  // bench-side view of the optional last-result cache
  bit          c_valid = 1'b0;
  logic [31:0] c_a = '0;
  logic [31:0] c_b = '0;
  bit          c_sgn = 1'b0;

  div_issue_ctrl #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src_a   (in_src_a),
    .in_src_b   (in_src_b),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .div_start  (div_start),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_sign   (div_sign),
    .div_result (div_result),
    .div_busy   (div_busy)
  );

  always #5 clk = ~clk;

  // {remainder, quotient} the divider produces for its latched operands
  function automatic logic [63:0] model_divide(input logic [31:0] a, input logic [31:0] b,
                                               input logic sgn);
    longint x, y, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // architectural result of an op, straight from the instruction semantics
  function automatic logic [31:0] expect_data(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
    if (!op[1]) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x - q * y;
    return op[0] ? r[31:0] : q[31:0];
  endfunction

  // Iterative divider: busy for N cycles after a start, garbage until done
  always @(negedge clk) begin
    if (div_start === 1'b1) begin
      start_count++;
      last_n         = int'($urandom_range(17, 2));
      busy_left      = last_n;
      div_busy       = 1'b1;
      pending_result = model_divide(div_a, div_b, div_sign);
      div_result     = {$urandom, $urandom};
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        div_busy   = 1'b0;
        div_result = pending_result;
      end else begin
        div_result = {$urandom, $urandom};
      end
    end
  end

  // present a request and return #1 after the edge that accepted it
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    int guard = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_src_a = a;
    in_src_b = b;
    in_tag   = tag;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (in_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("[TB] FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // one full op: accept, wait for result, optional stall, writeback handshake
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] tag,
                       input logic [31:0] exp, input int stall);
    int  s0;
    int  lat;
    int  exp_lat;
    bit  zero;
    bit  hit;
    zero = (b == 32'd0);
    hit  = CACHE_ON && !zero && c_valid && (c_a == a) && (c_b == b) && (c_sgn == !op[1]);
    s0   = start_count;
    send(op, a, b, tag);
    vectors++;
    if (div_start !== !(zero || hit)) begin
      miscompares++;
      $display("[TB] FAIL %s start_after_accept: got %b required %b", name, div_start, !(zero || hit));
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    exp_lat = (zero || hit) ? 0 : last_n + 1;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s result_timeout: out_valid=%b required 1", name, out_valid);
    end
    vectors++;
    if (lat != exp_lat) begin
      miscompares++;
      $display("[TB] FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    vectors++;
    if (out_data !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s data: got %h required %h", name, out_data, exp);
    end
    vectors++;
    if (out_tag !== tag) begin
      miscompares++;
      $display("[TB] FAIL %s tag: got %h required %h", name, out_tag, tag);
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp || out_tag !== tag || in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL %s stall_hold: got v=%b d=%h t=%h rdy=%b required v=1 d=%h t=%h rdy=0",
                 name, out_valid, out_data, out_tag, in_ready, exp, tag);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s handshake: got v=%b rdy=%b required v=0 rdy=1", name, out_valid, in_ready);
    end
    vectors++;
    if (start_count - s0 != ((zero || hit) ? 0 : 1)) begin
      miscompares++;
      $display("[TB] FAIL %s start_count: got %0d required %0d", name, start_count - s0,
               (zero || hit) ? 0 : 1);
    end
    if (!zero && !hit) begin
      c_valid = 1'b1;
      c_a     = a;
      c_b     = b;
      c_sgn   = !op[1];
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || div_start !== 1'b0 || out_data !== 32'd0 || out_tag !== '0 ||
        div_a !== 32'd0 || div_b !== 32'd0 || div_sign !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got v=%b st=%b d=%h t=%h a=%h b=%h s=%b required all 0",
               out_valid, div_start, out_data, out_tag, div_a, div_b, div_sign);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    do_op("div_100_7", OP_DIV, 32'd100, 32'd7, 5'h0B, 32'd14, 0);
    do_op("mod_m100_7", OP_MOD, 32'hFFFF_FF9C, 32'd7, 5'h15, 32'hFFFF_FFFE, 1);
    do_op("divu_max_2", OP_DIVU, 32'hFFFF_FFFF, 32'd2, 5'h03, 32'h7FFF_FFFF, 0);
  endtask

  task automatic test_zero_divisor();
    do_op("div_5_0", OP_DIV, 32'd5, 32'd0, 5'h1F, 32'hFFFF_FFFF, 0);
    do_op("mod_5_0", OP_MOD, 32'd5, 32'd0, 5'h01, 32'd5, 2);
  endtask

  task automatic test_overflow_stall();
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0E, 32'h8000_0000, 4);
    do_op("mod_ovf", OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0F, 32'd0, 0);
  endtask

  task automatic test_flush();
    bit saw;
    int s0;
    send(OP_DIV, 32'd1000, 32'd7, 5'h09);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_blocks_ready: got %b required 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    saw = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) saw = 1'b1;
    end
    vectors++;
    if (saw) begin
      miscompares++;
      $display("[TB] FAIL flush_wait_valid: got out_valid high required never");
    end
    do_op("after_flush", OP_DIV, 32'd9, 32'd3, 5'h12, 32'd3, 0);
    // flush while the start pulse is out: the pulse still goes to the divider
    s0 = start_count;
    send(OP_DIVU, 32'd50, 32'd6, 5'h04);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || start_count - s0 != 1) begin
      miscompares++;
      $display("[TB] FAIL flush_launch: got v=%b rdy=%b starts=%0d required v=0 rdy=1 starts=1",
               out_valid, in_ready, start_count - s0);
    end
  endtask

  task automatic test_reset_mid();
    send(OP_DIV, 32'd77, 32'd5, 5'h1A);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || div_start !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: got v=%b st=%b rdy=%b d=%h required v=0 st=0 rdy=1 d=0",
               out_valid, div_start, in_ready, out_data);
    end
    c_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("after_reset", OP_DIV, 32'd77, 32'd5, 5'h1B, 32'd15, 0);
  endtask

  task automatic test_cache();
    do_op("cache_div", OP_DIV, 32'd1000, 32'd33, 5'h06, 32'd30, 0);
    do_op("cache_mod", OP_MOD, 32'd1000, 32'd33, 5'h07, 32'd10, 0);
    do_op("cache_modu", OP_MODU, 32'd1000, 32'd33, 5'h08, 32'd10, 0);
  endtask

  task automatic test_random();
    logic [1:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    for (int i = 0; i < 30; i++) begin
      op  = 2'($urandom_range(3, 0));
      tag = TAG_W'($urandom);
      if (i == 0 || $urandom_range(4, 0) != 0) begin
        case ($urandom_range(3, 0))
          0:       a = $urandom;
          1:       a = 32'h8000_0000;
          2:       a = $urandom_range(200, 0);
          default: a = ~$urandom_range(200, 0);
        endcase
        case ($urandom_range(5, 0))
          0:       b = 32'd0;
          1:       b = 32'hFFFF_FFFF;
          2:       b = $urandom_range(16, 1);
          default: b = $urandom;
        endcase
      end
      do_op("random", op, a, b, tag, expect_data(op, a, b), int'($urandom_range(3, 0)));
    end
  endtask

  initial begin
    $display("[TB] div_issue_ctrl bench start");
    test_reset();
    test_basic();
    test_zero_divisor();
    test_overflow_stall();
    test_flush();
    test_reset_mid();
`ifdef DIV_RESULT_CACHE_EN
    test_cache();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
